// File: rtl/rfm_req_tracker.sv
// Pending-request tracker feeding the RFM issue-path priority encoder.
// Holds outstanding row requests and issues one encoder-selected index per cycle through a valid/ready slot.
module rfm_req_tracker #(
  parameter int N  = 256,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_vld,
  input  logic [IW-1:0] set_idx,
  input  logic          clr_all,
  output logic [N-1:0]  pe_oht,
  input  logic [IW-1:0] pe_bin,
  input  logic          pe_vld,
  output logic          out_vld,
  output logic [IW-1:0] out_idx,
  input  logic          out_rdy,
  output logic [IW:0]   pend_cnt,
  output logic          busy
);

  logic [N-1:0] pend_q;
  logic [N-1:0] pend_nxt;
  logic [N-1:0] hold_mask;
  logic         xfer;
  logic         load;
  logic         inc;
  logic         dec;
  logic [IW:0]  cnt_nxt;

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // The held index stays pending until accepted, but is hidden from the encoder
  // so the next choice is always a different entry.
  assign hold_mask = out_vld ? onehot(out_idx) : '0;
  assign pe_oht    = pend_q & ~hold_mask;
  assign xfer      = out_vld & out_rdy;
  assign load      = (~out_vld | xfer) & pe_vld;
  assign busy      = (|pend_q) | out_vld;

  always_comb begin
    pend_nxt = pend_q;
    inc      = 1'b0;
    dec      = 1'b0;
    cnt_nxt  = pend_cnt;
    if (clr_all) begin
      pend_nxt = '0;
      if (set_vld) pend_nxt[set_idx] = 1'b1;
      cnt_nxt = {{IW{1'b0}}, set_vld};
    end else begin
      if (xfer) pend_nxt[out_idx] = 1'b0;
      if (set_vld) pend_nxt[set_idx] = 1'b1;
      // A held entry is always pending, so a set colliding with its xfer is a no-op.
      inc     = set_vld & ~pend_q[set_idx];
      dec     = xfer & ~(set_vld & (set_idx == out_idx));
      cnt_nxt = pend_cnt + {{IW{1'b0}}, inc} - {{IW{1'b0}}, dec};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q   <= '0;
      pend_cnt <= '0;
      out_vld  <= 1'b0;
      out_idx  <= '0;
    end else begin
      pend_q   <= pend_nxt;
      pend_cnt <= cnt_nxt;
      if (clr_all) begin
        out_vld <= 1'b0;
      end else if (load) begin
        out_vld <= 1'b1;
        out_idx <= pe_bin;
      end else if (xfer) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule
